// File: rtl/hazard_branch_unit.sv
// Hazard, forwarding and branch-resolution control for the 5-stage pipeline.
// It holds a 2-bit saturating BHT that predicts branches held in D on an
// operand hazard. It also keeps saturating branch/mispredict counters.
module hazard_branch_unit #(
  parameter int BHT_BITS = 4,
  parameter int PC_W     = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic [5:0]       op,
  input  logic             equalD,
  input  logic [PC_W-1:0]  pcD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             brbitF,
  output logic             branchCorrect,
  output logic [1:0]       brmuxsel,
  output logic [CNT_W-1:0] branchCnt,
  output logic [CNT_W-1:0] mispredCnt
);

  localparam int BHT_N = 1 << BHT_BITS;

  typedef enum logic {S_RUN = 1'b0, S_SPEC = 1'b1} state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] v);
    return (v == 2'b00) ? v : v - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              r_state;
  state_t              w_next;
  logic                r_pred;
  logic [BHT_BITS-1:0] r_idx;
  logic [1:0]          r_bht [0:BHT_N-1];
  logic [CNT_W-1:0]    r_branch_cnt;
  logic [CNT_W-1:0]    r_mispred_cnt;

  logic [1:0]          w_fwd_ae;
  logic [1:0]          w_fwd_be;
  logic                w_fwd_ad;
  logic                w_fwd_bd;
  logic                w_lwstall;
  logic                w_brhaz;
  logic                w_stall;
  logic                w_taken;
  logic [BHT_BITS-1:0] w_idx;
  logic [1:0]          w_bht_rd;
  logic                w_brbit;
  logic                w_correct;
  logic [1:0]          w_mux;
  logic                w_resolve;
  logic                w_mispred;
  logic                w_latch;
  logic [BHT_BITS-1:0] w_upd_idx;
  logic [1:0]          w_bht_new;
  logic                w_unused_pc;

  // The BHT only looks at the low PC bits; the rest are intentionally ignored.
  assign w_unused_pc = ^pcD[PC_W-1:BHT_BITS];

  // Forwarding: M has the newer value, so it takes priority over W.
  assign w_fwd_ae = (rsE != 5'd0 && regwriteM && writeregM == rsE) ? 2'd2 :
                    (rsE != 5'd0 && regwriteW && writeregW == rsE) ? 2'd1 : 2'd0;
  assign w_fwd_be = (rtE != 5'd0 && regwriteM && writeregM == rtE) ? 2'd2 :
                    (rtE != 5'd0 && regwriteW && writeregW == rtE) ? 2'd1 : 2'd0;
  assign w_fwd_ad = (rsD != 5'd0) && regwriteM && (writeregM == rsD);
  assign w_fwd_bd = (rtD != 5'd0) && regwriteM && (writeregM == rtD);

  // A branch cannot compare until an E-stage ALU result or an M-stage load lands.
  assign w_lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign w_brhaz   = branchD &&
                     ((regwriteE && writeregE != 5'd0 &&
                       (writeregE == rsD || writeregE == rtD)) ||
                      (memtoregM && writeregM != 5'd0 &&
                       (writeregM == rsD || writeregM == rtD)));
  assign w_stall   = w_lwstall | w_brhaz;

  assign w_taken   = equalD ^ (op == 6'h05);
  assign w_idx     = pcD[BHT_BITS-1:0];
  assign w_bht_rd  = r_bht[w_idx];
  assign w_bht_new = w_taken ? sat_inc2(r_bht[w_upd_idx]) : sat_dec2(r_bht[w_upd_idx]);

  // Branch FSM next-state and outputs: speculate on a hazard, resolve once it clears.
  always_comb begin
    w_next    = r_state;
    w_brbit   = 1'b0;
    w_correct = 1'b0;
    w_mux     = 2'd0;
    w_resolve = 1'b0;
    w_mispred = 1'b0;
    w_latch   = 1'b0;
    w_upd_idx = w_idx;
    case (r_state)
      S_RUN: begin
        if (branchD) begin
          if (w_brhaz) begin
            w_latch = 1'b1;
            w_brbit = w_bht_rd[1];
            w_next  = S_SPEC;
          end else begin
            w_resolve = 1'b1;
            w_mux     = w_taken ? 2'd1 : 2'd0;
          end
        end
      end
      S_SPEC: begin
        if (!branchD) begin
          w_next = S_RUN;
        end else if (w_brhaz) begin
          w_brbit = r_pred;
        end else begin
          w_resolve = 1'b1;
          w_upd_idx = r_idx;
          w_next    = S_RUN;
          if (r_pred == w_taken) begin
            w_correct = 1'b1;
            w_mux     = w_taken ? 2'd1 : 2'd0;
          end else begin
            w_mispred = 1'b1;
            w_mux     = w_taken ? 2'd1 : 2'd2;
          end
        end
      end
      default: w_next = S_RUN;
    endcase
  end

  // FSM state plus the prediction and index captured on entry to SPEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_pred  <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_latch) begin
        r_pred <= w_bht_rd[1];
        r_idx  <= w_idx;
      end
    end
  end

  // BHT training at the resolving edge; entries start weakly not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
    end else if (w_resolve) begin
      r_bht[w_upd_idx] <= w_bht_new;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_resolve) r_branch_cnt  <= sat_cnt_inc(r_branch_cnt);
      if (w_mispred) r_mispred_cnt <= sat_cnt_inc(r_mispred_cnt);
    end
  end

  // Every output is forced low while reset is held.
  assign stallF        = reset & w_stall;
  assign stallD        = reset & w_stall;
  assign flushE        = reset & w_stall;
  assign forwardAD     = reset & w_fwd_ad;
  assign forwardBD     = reset & w_fwd_bd;
  assign forwardAE     = reset ? w_fwd_ae : 2'd0;
  assign forwardBE     = reset ? w_fwd_be : 2'd0;
  assign brbitF        = reset & w_brbit;
  assign branchCorrect = reset & w_correct;
  assign brmuxsel      = reset ? w_mux : 2'd0;
  assign branchCnt     = r_branch_cnt;
  assign mispredCnt    = r_mispred_cnt;

endmodule

// File: tb/tb_hazard_branch_unit.sv
// Directed bench for hazard_branch_unit: expected outputs are queued per
// cycle by the driver and checked at the falling edge by a monitor.
module tb_hazard_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic        branchD, equalD;
  logic [5:0]  op;
  logic [31:0] pcD;
  logic        stallF, stallD, flushE, forwardAD, forwardBD;
  logic [1:0]  forwardAE, forwardBE, brmuxsel;
  logic        brbitF, branchCorrect;
  logic [15:0] branchCnt, mispredCnt;

  always #5 clk = ~clk;

  hazard_branch_unit dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .op(op), .equalD(equalD), .pcD(pcD),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .brbitF(brbitF), .branchCorrect(branchCorrect), .brmuxsel(brmuxsel),
    .branchCnt(branchCnt), .mispredCnt(mispredCnt)
  );

  typedef struct packed {
    logic        stf;
    logic        std;
    logic        fle;
    logic [1:0]  fae;
    logic [1:0]  fbe;
    logic        fad;
    logic        fbd;
    logic        brb;
    logic        bc;
    logic [1:0]  mux;
    logic [15:0] bcnt;
    logic [15:0] mcnt;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  exp_t  m_e, m_a;
  string m_nm;

  function automatic exp_t mk(input logic st, input logic [1:0] fae, input logic [1:0] fbe,
                              input logic fad, input logic fbd, input logic brb,
                              input logic bc, input logic [1:0] mux,
                              input logic [15:0] bcnt, input logic [15:0] mcnt);
    exp_t e;
    e.stf = st; e.std = st; e.fle = st;
    e.fae = fae; e.fbe = fbe; e.fad = fad; e.fbd = fbd;
    e.brb = brb; e.bc = bc; e.mux = mux; e.bcnt = bcnt; e.mcnt = mcnt;
    return e;
  endfunction

  // Monitor: one expected entry per cycle, compared at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        m_e = q.pop_front();
        m_nm = nq.pop_front();
        m_a.stf = stallF; m_a.std = stallD; m_a.fle = flushE;
        m_a.fae = forwardAE; m_a.fbe = forwardBE;
        m_a.fad = forwardAD; m_a.fbd = forwardBD;
        m_a.brb = brbitF; m_a.bc = branchCorrect; m_a.mux = brmuxsel;
        m_a.bcnt = branchCnt; m_a.mcnt = mispredCnt;
        n_cmp++;
        if (m_a !== m_e) begin
          n_bad++;
          $display("FAIL %s: got stall=%b%b%b fAE=%0d fBE=%0d fAD=%b fBD=%b brbit=%b bc=%b mux=%0d bcnt=%0d mcnt=%0d ; want stall=%b%b%b fAE=%0d fBE=%0d fAD=%b fBD=%b brbit=%b bc=%b mux=%0d bcnt=%0d mcnt=%0d",
                   m_nm, m_a.stf, m_a.std, m_a.fle, m_a.fae, m_a.fbe, m_a.fad, m_a.fbd,
                   m_a.brb, m_a.bc, m_a.mux, m_a.bcnt, m_a.mcnt,
                   m_e.stf, m_e.std, m_e.fle, m_e.fae, m_e.fbe, m_e.fad, m_e.fbd,
                   m_e.brb, m_e.bc, m_e.mux, m_e.bcnt, m_e.mcnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0;
    branchD = 0; op = 6'h00; equalD = 0; pcD = 32'h0;
  endtask

  task automatic step(input string nm, input exp_t e);
    q.push_back(e);
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic br(input logic [5:0] o, input logic [31:0] pc, input logic eq);
    clr();
    branchD = 1; op = o; pcD = pc; equalD = eq; rsD = 1; rtD = 2;
  endtask

  initial begin
    reset = 0;
    clr();
    @(posedge clk);
    #1;

    rsE = 3; regwriteM = 1; writeregM = 3; branchD = 1; rsD = 3; regwriteE = 1; writeregE = 3;
    step("reset_outs", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1;

    clr(); rsE = 3; regwriteM = 1; writeregM = 3;
    step("fwd_M", mk(0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    clr(); rsE = 3; regwriteW = 1; writeregW = 3;
    step("fwd_W", mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    clr(); rsE = 3; rtE = 3; regwriteM = 1; writeregM = 3; regwriteW = 1; writeregW = 3;
    step("fwd_M_over_W", mk(0, 2, 2, 0, 0, 0, 0, 0, 0, 0));
    clr(); regwriteM = 1; regwriteW = 1;
    step("fwd_reg0", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clr(); rsD = 7; rtD = 8; regwriteM = 1; writeregM = 8;
    step("fwd_D", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    clr(); memtoregE = 1; regwriteE = 1; writeregE = 2; rtE = 2; rsD = 4; rtD = 2;
    step("lw_stall", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    clr(); memtoregM = 1; regwriteM = 1; writeregM = 2; rsD = 4; rtD = 2;
    step("lw_released", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

    br(6'h04, 32'h5, 1);
    step("beq_resolve", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    clr();
    step("beq_count", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    br(6'h05, 32'h5, 0); regwriteE = 1; writeregE = 1;
    step("bne_spec", mk(1, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    br(6'h05, 32'h5, 1); regwriteM = 1; writeregM = 1;
    step("bne_mispredict", mk(0, 0, 0, 1, 0, 0, 0, 2, 1, 0));
    clr();
    step("bne_counts", mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1));

    br(6'h04, 32'h5, 0); regwriteE = 1; writeregE = 1;
    step("bht5_weak_nt", mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    clr();
    step("abandon", mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    clr();
    step("abandon_nocount", mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 1));

    br(6'h04, 32'h5, 0); regwriteE = 1; writeregE = 1;
    step("spec_cycle1", mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    br(6'h04, 32'h5, 0); memtoregM = 1; regwriteM = 1; writeregM = 1;
    step("spec_cycle2", mk(1, 0, 0, 1, 0, 0, 0, 0, 2, 1));
    br(6'h04, 32'h5, 0); regwriteW = 1; writeregW = 1;
    step("spec_correct", mk(0, 0, 0, 0, 0, 0, 1, 0, 2, 1));
    clr();
    step("correct_count", mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 1));

    for (int i = 0; i < 4; i++) begin
      br(6'h04, 32'hF, 1);
      step($sformatf("sat_taken%0d", i), mk(0, 0, 0, 0, 0, 0, 0, 1, 16'(3 + i), 1));
    end
    br(6'h04, 32'hF, 0);
    step("F_not_taken", mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 1));
    br(6'h04, 32'hF, 1); regwriteE = 1; writeregE = 1;
    step("F_pred_after_sat", mk(1, 0, 0, 0, 0, 1, 0, 0, 8, 1));

    reset = 0;
    step("reset_in_spec", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1;
    clr();
    step("after_reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    br(6'h04, 32'hF, 1); regwriteE = 1; writeregE = 1;
    step("F_bht_reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    br(6'h04, 32'hF, 1);
    step("F_mispredict_taken", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    clr();
    step("final_counts", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
